// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - FIFO-fed 8N1 UART transmitter with 16x prescaler timing
// Bytes queue in a small write FIFO and are serialised LSB-first behind a start bit.
module uart_transmitter #(
  parameter int PRESCALER_WIDTH = 9,
  parameter int LIMIT           = 326,
  parameter int DBITS           = 8,
  parameter int SBITS           = 1,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] data_in,
  input  logic             wr_en,
  output logic             tx_full,
  output logic             tx_busy,
  output logic             tx_done,
  output logic             tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = (DBITS > 1) ? $clog2(DBITS) : 1;
  localparam logic [PRESCALER_WIDTH-1:0] PRE_LAST   = PRESCALER_WIDTH'(LIMIT - 1);
  localparam logic [NW-1:0]              DATA_LAST  = NW'(DBITS - 1);
  localparam logic [NW-1:0]              STOP_LAST  = NW'(SBITS - 1);
  localparam logic [AW:0]                COUNT_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [1:0]                 r_rst_sync;
  logic                       w_rst_n;

  logic [DBITS-1:0]           r_mem [FIFO_DEPTH];
  logic [AW-1:0]              r_wptr;
  logic [AW-1:0]              r_rptr;
  logic [AW:0]                r_count;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_empty;

  state_t                     r_state;
  state_t                     w_state_nxt;

  logic [PRESCALER_WIDTH-1:0] r_presc;
  logic [3:0]                 r_tcnt;
  logic                       w_tick;
  logic                       w_bit_end;

  logic [DBITS-1:0]           r_sh;
  logic [NW-1:0]              r_n;

  logic                       w_tx_nxt;
  logic                       w_frame_end;
  logic                       r_tx;
  logic                       r_done_pre;
  logic                       r_done;

  // Assertion is immediate; release reaches the core two clocks later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  assign w_empty = (r_count == '0);
  assign tx_full = (r_count == COUNT_FULL);
  assign w_push  = wr_en && !tx_full;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_tick    = (r_presc == PRE_LAST);
  assign w_bit_end = w_tick && (r_tcnt == 4'hF);

  // Held at zero while idle so every bit of a frame is a full 16*LIMIT clocks.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_presc <= '0;
      r_tcnt  <= '0;
    end else if (r_state == S_IDLE) begin
      r_presc <= '0;
      r_tcnt  <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end && (r_n == DATA_LAST)) begin
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_end && (r_n == STOP_LAST)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_tx_nxt    = 1'b1;
    w_pop       = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      S_IDLE:  w_pop       = !w_empty;
      S_START: w_tx_nxt    = 1'b0;
      S_DATA:  w_tx_nxt    = r_sh[0];
      S_STOP:  w_frame_end = w_bit_end && (r_n == STOP_LAST);
      default: w_tx_nxt    = 1'b1;
    endcase
  end

  // r_n indexes data bits in DATA and stop bits in STOP.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sh <= '0;
      r_n  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_sh <= r_mem[r_rptr];
          end
          r_n <= '0;
        end
        S_START: begin
          if (w_bit_end) begin
            r_n <= '0;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_sh <= r_sh >> 1;
            r_n  <= (r_n == DATA_LAST) ? '0 : r_n + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_n <= (r_n == STOP_LAST) ? '0 : r_n + 1'b1;
          end
        end
        default: r_n <= '0;
      endcase
    end
  end

  // Line and done are both one register behind the state so done marks the end of the stop bit on tx.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_tx       <= 1'b1;
      r_done_pre <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_tx       <= w_tx_nxt;
      r_done_pre <= w_frame_end;
      r_done     <= r_done_pre;
    end
  end

  assign tx      = r_tx;
  assign tx_done = r_done;
  assign tx_busy = !w_empty || (r_state != S_IDLE) || r_done_pre || r_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - scoreboard bench for uart_transmitter (LIMIT=4, SBITS 1 and 2)
module tb_uart_transmitter;

  localparam int BIT   = 64;
  localparam int FRAME = 640;

  typedef struct {
    logic [7:0] b;
    int         pop;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       wr_en;
  logic       tx_full, tx_busy, tx_done, tx;
  logic [7:0] data_in2;
  logic       wr_en2;
  logic       tx_full2, tx_busy2, tx_done2, tx2;

  int   cyc;
  int   checks;
  int   errors;
  int   n_done;
  int   total_acc;
  int   last_pop;
  bit   mon_en;
  exp_t exp_q[$];
  int   acc_pop[$];

  uart_transmitter #(
    .PRESCALER_WIDTH(9), .LIMIT(4), .DBITS(8), .SBITS(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .wr_en(wr_en),
    .tx_full(tx_full), .tx_busy(tx_busy), .tx_done(tx_done), .tx(tx)
  );

  uart_transmitter #(
    .PRESCALER_WIDTH(9), .LIMIT(4), .DBITS(8), .SBITS(2), .FIFO_DEPTH(4)
  ) dut2 (
    .clk(clk), .reset(reset), .data_in(data_in2), .wr_en(wr_en2),
    .tx_full(tx_full2), .tx_busy(tx_busy2), .tx_done(tx_done2), .tx(tx2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial n_done = 0;
  always @(negedge clk) if (tx_done) n_done <= n_done + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, req);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Occupancy model: an entry occupies the FIFO from its write edge up to and including its pop edge.
  task automatic write_byte(input logic [7:0] b, input bit track, output int w, output int p);
    int occ;
    w   = cyc + 1;
    occ = 0;
    foreach (acc_pop[i]) if (acc_pop[i] >= w) occ++;
    chk("tx_full_before_write", tx_full, (occ == 4));
    data_in = b;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    p = -1;
    if (occ < 4) begin
      p = (w + 1 > last_pop + FRAME + 1) ? w + 1 : last_pop + FRAME + 1;
      acc_pop.push_back(p);
      last_pop = p;
      if (track) begin
        exp_q.push_back('{b, p});
        total_acc++;
      end
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || tx_busy) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d pending expected=0", exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin : monitor
    logic       prev;
    logic       got_start, got_stop;
    logic [7:0] got;
    int         f, d;
    exp_t       e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev && !tx) begin
        f = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", exp_q.size(), 1);
          e = '{8'h00, f - 1};
        end else begin
          e = exp_q.pop_front();
        end
        repeat (BIT / 2) @(negedge clk);
        got_start = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          got[i] = tx;
        end
        repeat (BIT) @(negedge clk);
        got_stop = tx;
        d = -1;
        for (int k = 0; k < 200; k++) begin
          if (tx_done) begin
            d = cyc;
            break;
          end
          @(negedge clk);
        end
        chk("frame_start_edge", f, e.pop + 1);
        chk("start_bit", got_start, 0);
        chk("data_byte", got, e.b);
        chk("stop_bit", got_stop, 1);
        chk("done_edge", d, f + FRAME);
      end
      prev = tx;
    end
  end

  initial begin : stim
    int         w, p, wa, pa, pb, f2, d2, lows, n0;
    logic [7:0] v2;
    logic       eb;
    checks = 0; errors = 0; total_acc = 0; last_pop = -100000; mon_en = 1'b1;
    wr_en = 1'b0; data_in = '0; wr_en2 = 1'b0; data_in2 = '0;
    reset = 1'b0;

    repeat (5) @(negedge clk);
    chk("rst_tx_held", tx, 1);
    chk("rst_busy_held", tx_busy, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_full", tx_full, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_tx2", tx2, 1);
    chk("rst_full2", tx_full2, 0);
    repeat (4) @(negedge clk);

    // Two stop bits on the second instance.
    v2 = 8'h81;
    w  = cyc + 1;
    data_in2 = v2;
    wr_en2   = 1'b1;
    @(negedge clk);
    wr_en2 = 1'b0;
    f2 = w + 2;
    wait_until(f2 - 1);
    chk("sb2_pre_fall", tx2, 1);
    wait_until(f2);
    chk("sb2_fall", tx2, 0);
    for (int i = 0; i < 11; i++) begin
      wait_until(f2 + BIT / 2 + BIT * i);
      if (i == 0) eb = 1'b0;
      else if (i <= 8) eb = v2[i-1];
      else eb = 1'b1;
      chk($sformatf("sb2_bit%0d", i), tx2, eb);
    end
    wait_until(f2 + 576);
    chk("sb2_stop_first", tx2, 1);
    wait_until(f2 + 703);
    chk("sb2_stop_last", tx2, 1);
    d2 = -1;
    for (int k = 0; k < 200; k++) begin
      if (tx_done2) begin
        d2 = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("sb2_done_edge", d2, f2 + 704);
    @(negedge clk);
    chk("sb2_done_width", tx_done2, 0);
    chk("sb2_busy_drop", tx_busy2, 0);

    // Single byte with busy/done timing.
    write_byte(8'hA5, 1'b1, w, p);
    chk("single_busy_rise", tx_busy, 1);
    wait_until(w + 2 + FRAME);
    chk("single_done", tx_done, 1);
    chk("single_busy_at_done", tx_busy, 1);
    @(negedge clk);
    chk("single_busy_drop", tx_busy, 0);
    chk("single_done_width", tx_done, 0);
    wait_idle();

    // Back-to-back fill: one byte goes straight out, four fill the FIFO, 0x99 is dropped.
    write_byte(8'hE7, 1'b1, wa, pa);
    write_byte(8'h00, 1'b1, w, pb);
    write_byte(8'hFF, 1'b1, w, p);
    write_byte(8'h55, 1'b1, w, p);
    write_byte(8'h0F, 1'b1, w, p);
    write_byte(8'h99, 1'b1, w, p);
    chk("b2b_full_after_drop", tx_full, 1);
    wait_until(pb - 1);
    chk("b2b_full_before_pop", tx_full, 1);
    wait_until(pb);
    chk("b2b_full_after_pop", tx_full, 0);
    wait_idle();

    // Push on the same edge as the pop.
    write_byte(8'h12, 1'b1, w, pa);
    write_byte(8'h34, 1'b1, w, pb);
    wait_until(pb - 1);
    write_byte(8'h56, 1'b1, w, p);
    chk("pushpop_edge", w, pb);
    chk("pushpop_not_full", tx_full, 0);
    wait_idle();

    // Randomised writes, with occasional bursts that hit the full condition.
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) != 0) repeat ($urandom_range(0, 700)) @(negedge clk);
      write_byte(8'($urandom), 1'b1, w, p);
    end
    wait_idle();

    // Reset in the middle of data bit 3 of 0x3C.
    mon_en = 1'b0;
    write_byte(8'h3C, 1'b0, w, p);
    wait_until(p + 1 + BIT / 2 + BIT);
    chk("mid_bit0", tx, 0);
    wait_until(p + 1 + BIT / 2 + BIT * 4);
    chk("mid_bit3", tx, 1);
    chk("mid_busy", tx_busy, 1);
    n0 = n_done;
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", tx_busy, 0);
    chk("mid_rst_full", tx_full, 0);
    chk("mid_rst_done", tx_done, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    acc_pop.delete();
    last_pop = -100000;
    lows = 0;
    repeat (700) begin
      @(negedge clk);
      if (!tx) lows++;
    end
    chk("mid_line_quiet", lows, 0);
    chk("mid_no_done", n_done, n0);
    mon_en = 1'b1;
    write_byte(8'hC3, 1'b1, w, p);
    wait_idle();

    chk("done_pulse_count", n_done, total_acc);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
